// File: rtl/lut_multiplier_seq_pkg.sv
// Shared definitions for the sequential LUT multiplier: FSM encoding and width helpers.
package lut_multiplier_seq_pkg;

    // Largest B slice consumed per cycle; the LUT grows as 2^DIGIT.
    localparam int unsigned LutMulMaxDigit = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } lut_mul_state_e;

    // Product width: the full unsigned product never needs more than WIDTH_A + WIDTH_B bits.
    function automatic int unsigned lut_mul_nwidth(input int unsigned width_a,
                                                   input int unsigned width_b);
        return width_a + width_b;
    endfunction

endpackage

// File: rtl/lut_multiplier_seq_if.sv
// Start/ready/done handshake bundle between a requesting datapath and the multiplier.
interface lut_multiplier_seq_if
    import lut_multiplier_seq_pkg::*;
#(
    parameter int unsigned WIDTH_A = 32,
    parameter int unsigned WIDTH_B = 32
);
    localparam int unsigned WidthM = lut_mul_nwidth(WIDTH_A, WIDTH_B);

    logic               start;
    logic [WIDTH_A-1:0] A;
    logic [WIDTH_B-1:0] B;
    logic               ready;
    logic               done;
    logic [WidthM-1:0]  M;

    // Requester side.
    modport master (
        output start,
        output A,
        output B,
        input  ready,
        input  done,
        input  M
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  A,
        input  B,
        output ready,
        output done,
        output M
    );

endinterface

// File: rtl/lut_multiple_table.sv
// Combinational table of the multiples a_reg * k, k = 0 .. 2^DIGIT-1, selected by index.
module lut_multiple_table #(
    parameter int unsigned WIDTH_A = 32,
    parameter int unsigned DIGIT   = 4
) (
    input  logic [WIDTH_A-1:0]       a_reg,
    input  logic [DIGIT-1:0]         index,
    output logic [WIDTH_A+DIGIT-1:0] multiple
);
    localparam int unsigned WidthT  = WIDTH_A + DIGIT;
    localparam int unsigned Entries = 1 << DIGIT;

    logic [WidthT-1:0] lut [Entries];

    // Multiple of a for a constant k, summed from the shifted copies of a picked by the bits of k.
    function automatic logic [WidthT-1:0] shift_add_multiple(input logic [WIDTH_A-1:0] a,
                                                             input int unsigned k);
        logic [WidthT-1:0] sum;
        sum = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (k[j]) begin
                sum = sum + (WidthT'(a) << j);
            end
        end
        return sum;
    endfunction

    for (genvar k = 0; k < Entries; k++) begin : gen_entry
        assign lut[k] = shift_add_multiple(a_reg, k);
    end

    assign multiple = lut[index];

endmodule

// File: rtl/lut_multiplier_seq.sv
// Multi-cycle unsigned multiplier: consumes B one DIGIT-bit slice per clock, MSB slice first,
// adding the LUT multiple of A selected by each slice into a left-shifting accumulator.
module lut_multiplier_seq
    import lut_multiplier_seq_pkg::*;
#(
    parameter int unsigned WIDTH_A = 32,
    parameter int unsigned WIDTH_B = 32,
    parameter int unsigned DIGIT   = 4
) (
    input  logic                clk,
    input  logic                reset,
    lut_multiplier_seq_if.slave bus
);
    localparam int unsigned WidthM = lut_mul_nwidth(WIDTH_A, WIDTH_B);
    localparam int unsigned WidthT = WIDTH_A + DIGIT;
    localparam int unsigned Ndig   = WIDTH_B / DIGIT;
    localparam int unsigned CntW   = (Ndig > 1) ? $clog2(Ndig) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(Ndig - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    lut_mul_state_e     state_q;
    logic [WIDTH_A-1:0] a_q;
    logic [WIDTH_B-1:0] b_q;
    logic [WidthM-1:0]  acc_q;
    logic [CntW-1:0]    cnt_q;
    logic [WidthM-1:0]  m_q;
    logic               done_q;
    logic               ready_q;

    logic [DIGIT-1:0]   digit_idx;
    logic [WidthT-1:0]  multiple;
    logic [WidthM-1:0]  acc_step;

    // The slice currently at the top of the shifting B register selects the LUT entry.
    assign digit_idx = b_q[WIDTH_B-1 -: DIGIT];

    lut_multiple_table #(
        .WIDTH_A(WIDTH_A),
        .DIGIT  (DIGIT)
    ) u_table (
        .a_reg   (a_q),
        .index   (digit_idx),
        .multiple(multiple)
    );

    // One radix-2^DIGIT Horner step: shift the running sum and add the selected multiple.
    always_comb begin
        acc_step = (acc_q << DIGIT) + WidthM'(multiple);
    end

    // Control FSM with operand/accumulator registers and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
                StIdle, StDone: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        acc_q   <= '0;
                        cnt_q   <= CntLast;
                        ready_q <= 1'b0;
                        state_q <= StRun;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    b_q   <= b_q << DIGIT;
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == '0) begin
                        m_q     <= acc_step;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.M     = m_q;

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// Randomised self-checking bench: default 32x32/DIGIT=4 instance plus a 16x8 DIGIT sweep.
module tb_lut_multiplier_seq;

    logic clk = 1'b0;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lut_multiplier_seq_if bus ();

    lut_multiplier_seq u_dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands with a one-cycle start; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Wait for done; cycles counts edges after acceptance (-1 on timeout). Optionally pulses
    // a stray start with junk operands after edge pulse_at.
    task automatic wait_done(input int budget, input int pulse_at, output int cycles,
                             output int ready_hi, output int m_moves);
        logic [63:0] m_prev;
        m_prev   = bus.M;
        cycles   = -1;
        ready_hi = 0;
        m_moves  = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                cycles = c;
                break;
            end
            if (bus.ready) ready_hi++;
            if (bus.M !== m_prev) m_moves++;
            if (c == pulse_at) begin
                bus.start = 1'b1;
                bus.A     = $urandom;
                bus.B     = $urandom;
            end
        end
    endtask

    // Parameter sweep: 16x8 operands with DIGIT = 1, 2, 4, each with its own reset.
    for (genvar g = 0; g < 3; g++) begin : gen_sweep
        localparam int unsigned Dig = 1 << g;
        localparam int          Lat = 8 / Dig;

        logic rst_sw;
        logic fin;

        lut_multiplier_seq_if #(.WIDTH_A(16), .WIDTH_B(8)) sw_bus ();

        lut_multiplier_seq #(
            .WIDTH_A(16),
            .WIDTH_B(8),
            .DIGIT  (Dig)
        ) u_dut (
            .clk  (clk),
            .reset(rst_sw),
            .bus  (sw_bus)
        );

        initial begin
            logic [15:0] a;
            logic [7:0]  b;
            int          cyc;
            fin          = 1'b0;
            rst_sw       = 1'b0;
            sw_bus.start = 1'b0;
            sw_bus.A     = '0;
            sw_bus.B     = '0;
            repeat (3) @(posedge clk);
            #1 rst_sw = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                a = 16'($urandom);
                b = 8'($urandom);
                if (i == 0) begin
                    a = 16'hFFFF;
                    b = 8'hFF;
                end else if (i == 1) begin
                    a = '0;
                end else if (i == 2) begin
                    b = '0;
                end
                // Every third op leaves an idle gap; the rest issue back-to-back from DONE.
                if (i % 3 == 2) begin
                    @(posedge clk);
                    #1;
                end
                sw_bus.start = 1'b1;
                sw_bus.A     = a;
                sw_bus.B     = b;
                @(posedge clk);
                #1;
                sw_bus.start = 1'b0;
                sw_bus.A     = 16'($urandom);
                sw_bus.B     = 8'($urandom);
                cyc = -1;
                for (int c = 1; c <= 20; c++) begin
                    @(posedge clk);
                    #1;
                    if (sw_bus.done) begin
                        cyc = c;
                        break;
                    end
                end
                check_eq($sformatf("d%0d_latency", Dig), 64'(cyc), 64'(Lat));
                check_eq($sformatf("d%0d_product a=%0h b=%0h", Dig, a, b), 64'(sw_bus.M),
                         64'(a) * 64'(b));
            end
            fin = 1'b1;
        end
    end

    initial begin
        int          lat;
        int          rhi;
        int          mmv;
        int          dcnt;
        int          gap;
        logic [31:0] a;
        logic [31:0] b;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset and idle behaviour.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(bus.ready), 64'd1);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_m", 64'(bus.M), 64'd0);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dcnt++;
        end
        check_eq("idle_no_done", 64'(dcnt), 64'd0);
        check_eq("idle_ready", 64'(bus.ready), 64'd1);

        // Basic 3 x 5.
        issue(32'd3, 32'd5);
        check_eq("basic_ready_low", 64'(bus.ready), 64'd0);
        wait_done(20, 0, lat, rhi, mmv);
        check_eq("basic_latency", 64'(lat), 64'd8);
        check_eq("basic_product", bus.M, 64'd15);
        check_eq("basic_ready_mid", 64'(rhi), 64'd0);
        check_eq("basic_m_stable", 64'(mmv), 64'd0);
        check_eq("done_ready_both", 64'(bus.ready), 64'd1);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 64'(bus.done), 64'd0);

        // Extreme operands.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(20, 0, lat, rhi, mmv);
        check_eq("max_latency", 64'(lat), 64'd8);
        check_eq("max_product", bus.M, 64'hFFFF_FFFE_0000_0001);
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        issue(a, b);
        wait_done(20, 0, lat, rhi, mmv);
        check_eq("fixed_product", bus.M, 64'(a) * 64'(b));
        issue(32'd0, 32'hDEAD_BEEF);
        wait_done(20, 0, lat, rhi, mmv);
        check_eq("zero_a_latency", 64'(lat), 64'd8);
        check_eq("zero_a_product", bus.M, 64'd0);

        // Random operands, each issued from DONE or IDLE.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) begin
                @(posedge clk);
                #1;
            end
            issue(a, b);
            wait_done(20, 0, lat, rhi, mmv);
            check_eq("rand_latency", 64'(lat), 64'd8);
            check_eq($sformatf("rand_product a=%0h b=%0h", a, b), bus.M, 64'(a) * 64'(b));
            check_eq("rand_m_stable", 64'(mmv), 64'd0);
        end

        // Back-to-back with a stray start mid-RUN that must be ignored.
        a = $urandom;
        b = $urandom;
        issue(32'h0000_BEEF, 32'h0001_0203);
        wait_done(20, 0, lat, rhi, mmv);
        check_eq("b2b_first", bus.M, 64'h0000_BEEF * 64'h0001_0203);
        issue(a, b);
        gap = 1;
        wait_done(20, 3, lat, rhi, mmv);
        check_eq("b2b_period", 64'(gap + lat), 64'd9);
        check_eq("b2b_ignored_start", bus.M, 64'(a) * 64'(b));
        check_eq("b2b_ready_mid", 64'(rhi), 64'd0);

        // Asynchronous reset in the middle of a run.
        issue(32'hCAFE_F00D, 32'h8765_4321);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_reset_m_held", bus.M, 64'(a) * 64'(b));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_m", bus.M, 64'd0);
        check_eq("async_rst_ready", 64'(bus.ready), 64'd1);
        dcnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) dcnt++;
        end
        check_eq("abort_no_done", 64'(dcnt), 64'd0);
        issue(32'd7, 32'd9);
        wait_done(20, 0, lat, rhi, mmv);
        check_eq("post_rst_latency", 64'(lat), 64'd8);
        check_eq("post_rst_product", bus.M, 64'd63);

        // Let the sweep finish, bounded.
        for (int c = 0; c < 30000; c++) begin
            if (gen_sweep[0].fin && gen_sweep[1].fin && gen_sweep[2].fin) break;
            @(posedge clk);
        end
        check_eq("sweep_complete",
                 64'({gen_sweep[0].fin, gen_sweep[1].fin, gen_sweep[2].fin}), 64'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
